// File: rtl/register_divider_if.sv
// Command/result bus of the register divider. The bench drives the
// command side through the master modport; the divider sits on the slave side.
interface register_divider_if #(
    parameter int p_data_width = 7
);
    logic [2*p_data_width-1:0] i_w_dividend;
    logic [p_data_width-1:0]   i_w_divisor;
    logic                      i_w_write;
    logic                      i_w_divide;
    logic                      i_w_display;
    logic [2*p_data_width-1:0] o_w_quotient;
    logic [p_data_width-1:0]   o_w_remainder;
    logic                      o_w_busy;
    logic                      o_w_done;
    logic                      o_w_div_by_zero;

    modport master (
        output i_w_dividend, i_w_divisor, i_w_write, i_w_divide, i_w_display,
        input  o_w_quotient, o_w_remainder, o_w_busy, o_w_done, o_w_div_by_zero
    );

    modport slave (
        input  i_w_dividend, i_w_divisor, i_w_write, i_w_divide, i_w_display,
        output o_w_quotient, o_w_remainder, o_w_busy, o_w_done, o_w_div_by_zero
    );
endinterface

// File: rtl/register_divider.sv
// Command-driven restoring divider: a 2N-bit dividend by an N-bit divisor,
// one quotient bit per cycle MSB first. Results are held in registers and only
// driven onto the outputs while the FSM sits in DISPLAY.
module register_divider #(
    parameter int p_data_width = 7
) (
    input  logic          i_w_clk,
    input  logic          i_w_reset,
    register_divider_if.slave bus
);
    localparam int N     = p_data_width;
    localparam int W     = 2 * p_data_width;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DIVIDE,
        DISPLAY
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [W-1:0]     dividend_reg;
    logic [N-1:0]     divisor_reg;
    // The partial remainder is always below the divisor after an iteration,
    // so N bits are stored; the shifted value below is N+1 bits to hold the
    // overflow bit before the compare.
    logic [N-1:0]     rem_reg;
    logic [W-1:0]     work_q;
    logic [CNT_W-1:0] iter_cnt;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [W-1:0]     quotient_res;
    logic [N-1:0]     remainder_res;

    logic             start;
    logic             divisor_zero;
    logic [N:0]       rem_shift;
    logic             fits;
    logic [N:0]       rem_next;
    logic [W-1:0]     q_next;

    // The first cycle in DIVIDE (not yet busy) either finishes a divide by
    // zero or seeds the iteration registers.
    assign start        = (state == DIVIDE) && !busy;
    assign divisor_zero = (divisor_reg == '0);

    // One restoring shift-subtract step: bring in the next dividend bit and
    // subtract the divisor when it fits.
    always_comb begin
        rem_shift = {rem_reg, work_q[W-1]};
        fits      = (rem_shift >= {1'b0, divisor_reg});
        rem_next  = fits ? (rem_shift - {1'b0, divisor_reg}) : rem_shift;
        q_next    = {work_q[W-2:0], fits};
    end

    // State register.
    always_ff @(posedge i_w_clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the values from before the edge, independent of block order.
        if (i_w_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection: iteration owns the FSM while busy, otherwise the
    // commands pick the state by priority write > divide > display.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch
        // is inferred.
        next_state = IDLE;
        if (busy) begin
            next_state = (iter_cnt == LAST_ITER) ? IDLE : DIVIDE;
        end else if (start) begin
            next_state = divisor_zero ? IDLE : DIVIDE;
        end else if (bus.i_w_write) begin
            next_state = WRITE;
        end else if (bus.i_w_divide) begin
            next_state = DIVIDE;
        end else if (bus.i_w_display) begin
            next_state = DISPLAY;
        end
    end

    // Operand capture, iteration datapath and result commit.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            rem_reg       <= '0;
            work_q        <= '0;
            iter_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            div_by_zero   <= 1'b0;
            quotient_res  <= '0;
            remainder_res <= '0;
        end else begin
            done <= 1'b0;

            if (state == WRITE) begin
                dividend_reg <= bus.i_w_dividend;
                divisor_reg  <= bus.i_w_divisor;
            end

            if (start) begin
                if (divisor_zero) begin
                    quotient_res  <= '1;
                    remainder_res <= '0;
                    div_by_zero   <= 1'b1;
                    done          <= 1'b1;
                end else begin
                    rem_reg  <= '0;
                    work_q   <= dividend_reg;
                    iter_cnt <= '0;
                    busy     <= 1'b1;
                end
            end else if (busy) begin
                rem_reg  <= rem_next[N-1:0];
                work_q   <= q_next;
                iter_cnt <= iter_cnt + CNT_W'(1);
                if (iter_cnt == LAST_ITER) begin
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    div_by_zero   <= 1'b0;
                    quotient_res  <= q_next;
                    remainder_res <= rem_next[N-1:0];
                end
            end
        end
    end

    // Results are visible only in DISPLAY; flags come straight from registers.
    assign bus.o_w_quotient    = (state == DISPLAY) ? quotient_res  : '0;
    assign bus.o_w_remainder   = (state == DISPLAY) ? remainder_res : '0;
    assign bus.o_w_busy        = busy;
    assign bus.o_w_done        = done;
    assign bus.o_w_div_by_zero = div_by_zero;

endmodule

// File: tb/tb_register_divider.sv
// Self-checking bench for register_divider (N = 7): directed vector table,
// randomized operands against an arithmetic model, and hand-written
// sequences for busy-time command blocking and mid-division reset.
module tb_register_divider;
    localparam int N = 7;
    localparam int W = 2 * N;

    typedef struct {
        logic [W-1:0] a;
        logic [N-1:0] b;
        logic [W-1:0] q;
        logic [N-1:0] r;
        bit           dbz;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   prev_dbz;

    always #5 clk = ~clk;

    register_divider_if #(.p_data_width(N)) bus ();

    register_divider #(.p_data_width(N)) dut (
        .i_w_clk   (clk),
        .i_w_reset (reset),
        .bus       (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance one clock and land 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [W-1:0] a, input logic [N-1:0] b);
        bus.i_w_dividend = a;
        bus.i_w_divisor  = b;
        bus.i_w_write    = 1'b1;
        step();
        bus.i_w_write = 1'b0;
        step();
    endtask

    // Raise display, check the result is visible one cycle later, drop it,
    // check the outputs return to 0.
    task automatic show(input string tag, input logic [W-1:0] q, input logic [N-1:0] r);
        check($sformatf("%s_pre_q", tag), bus.o_w_quotient, 0);
        bus.i_w_display = 1'b1;
        step();
        check($sformatf("%s_q", tag), bus.o_w_quotient, q);
        check($sformatf("%s_r", tag), bus.o_w_remainder, r);
        bus.i_w_display = 1'b0;
        step();
        check($sformatf("%s_off_q", tag), bus.o_w_quotient, 0);
        check($sformatf("%s_off_r", tag), bus.o_w_remainder, 0);
    endtask

    // Issue divide and watch a bounded window: busy shape, single done pulse,
    // latency, sticky flag. With inject set, every command is pulsed with
    // 20/3 mid-division and must be ignored.
    task automatic run_divide(input string tag, input logic [W-1:0] q, input logic [N-1:0] r,
                              input bit dbz, input bit inject);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        bit shape_ok = 1'b1;
        bus.i_w_divide = 1'b1;
        step();
        bus.i_w_divide = 1'b0;
        for (int k = 1; k <= W + 4; k++) begin
            step();
            if (bus.o_w_busy === 1'b1) busy_cnt++;
            if (bus.o_w_busy !== (!dbz && k <= W)) shape_ok = 1'b0;
            if (bus.o_w_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    check($sformatf("%s_dbz_at_done", tag), bus.o_w_div_by_zero, dbz);
                    check($sformatf("%s_hidden_q", tag), bus.o_w_quotient, 0);
                end
            end
            if (inject && k == 5) begin
                bus.i_w_dividend = 20;
                bus.i_w_divisor  = 3;
                bus.i_w_write    = 1'b1;
                bus.i_w_divide   = 1'b1;
                bus.i_w_display  = 1'b1;
            end
            if (inject && k == 6) begin
                bus.i_w_write   = 1'b0;
                bus.i_w_divide  = 1'b0;
                bus.i_w_display = 1'b0;
            end
        end
        check($sformatf("%s_busy_cycles", tag), busy_cnt, dbz ? 0 : W);
        check($sformatf("%s_busy_shape", tag), shape_ok, 1);
        check($sformatf("%s_done_pulses", tag), done_cnt, 1);
        check($sformatf("%s_latency", tag), done_at, dbz ? 1 : W + 1);
        show(tag, q, r);
        check($sformatf("%s_dbz_after", tag), bus.o_w_div_by_zero, dbz);
        prev_dbz = dbz;
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] a, input logic [N-1:0] b,
                           input logic [W-1:0] q, input logic [N-1:0] r, input bit dbz);
        do_write(a, b);
        check($sformatf("%s_dbz_sticky", tag), bus.o_w_div_by_zero, prev_dbz);
        run_divide(tag, q, r, dbz, 1'b0);
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] all_ones;
        logic [W-1:0] ra;
        logic [N-1:0] rb;
        logic [W-1:0] mq;
        logic [N-1:0] mr;
        bit           mdbz;
        int           done_seen;

        all_ones = '1;
        vecs[0] = '{a: 100,   b: 7,   q: 14,    r: 2, dbz: 1'b0};
        vecs[1] = '{a: 16383, b: 127, q: 129,   r: 0, dbz: 1'b0};
        vecs[2] = '{a: 5,     b: 9,   q: 0,     r: 5, dbz: 1'b0};
        vecs[3] = '{a: 50,    b: 0,   q: 16383, r: 0, dbz: 1'b1};
        vecs[4] = '{a: 50,    b: 5,   q: 10,    r: 0, dbz: 1'b0};
        vecs[5] = '{a: 16383, b: 1,   q: 16383, r: 0, dbz: 1'b0};

        bus.i_w_dividend = '0;
        bus.i_w_divisor  = '0;
        bus.i_w_write    = 1'b0;
        bus.i_w_divide   = 1'b0;
        bus.i_w_display  = 1'b0;
        reset            = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        check("rst_busy", bus.o_w_busy, 0);
        check("rst_done", bus.o_w_done, 0);
        check("rst_dbz", bus.o_w_div_by_zero, 0);
        check("rst_q", bus.o_w_quotient, 0);
        check("rst_r", bus.o_w_remainder, 0);
        show("rst_show", 0, 0);
        prev_dbz = 1'b0;

        // Divide with no prior write: operands are 0/0.
        run_divide("nowrite", all_ones, 0, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++)
            full_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
            if (rb == 0) begin
                mq = all_ones; mr = 0; mdbz = 1'b1;
            end else begin
                mq = ra / W'(rb); mr = N'(ra % W'(rb)); mdbz = 1'b0;
            end
            full_op($sformatf("rnd%0d", i), ra, rb, mq, mr, mdbz);
        end

        // Commands while busy are ignored; operands stay 100/7.
        do_write(100, 7);
        run_divide("busy_inject", 14, 2, 1'b0, 1'b1);
        run_divide("operands_kept", 14, 2, 1'b0, 1'b0);
        do_write(20, 3);
        show("write_no_touch", 14, 2);

        // Reset in the middle of a division, with the sticky flag set beforehand.
        full_op("pre_reset_dbz", 50, 0, all_ones, 0, 1'b1);
        do_write(100, 7);
        done_seen = 0;
        bus.i_w_divide = 1'b1;
        step();
        bus.i_w_divide = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (bus.o_w_done === 1'b1) done_seen++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", bus.o_w_busy, 0);
        check("midrst_done", bus.o_w_done, 0);
        check("midrst_dbz", bus.o_w_div_by_zero, 0);
        check("midrst_q", bus.o_w_quotient, 0);
        check("midrst_r", bus.o_w_remainder, 0);
        for (int k = 0; k < W + 4; k++) begin
            step();
            if (bus.o_w_done === 1'b1) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        show("midrst_show", 0, 0);
        prev_dbz = 1'b0;
        run_divide("post_reset_nowrite", all_ones, 0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
